// File: rtl/chunk_out_sched_if.sv
// Handshake bundle for chunk_out_sched: requester side and chunk stream side.
// master = scheduler, slave = the requesters and the stream sink.
interface chunk_out_sched_if #(
    parameter int NUM_REQ    = 4,
    parameter int CHUNK_BITS = 4,
    parameter int NUM_CHUNKS = 8
);
    localparam int DATA_BITS = NUM_CHUNKS * CHUNK_BITS;
    localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           ack;
    logic                         out_valid;
    logic                         out_ready;
    logic [CHUNK_BITS-1:0]        out_bits;
    logic                         out_last;
    logic [SRC_W-1:0]             out_src;
    logic                         busy;

    modport master (
        input  req, req_data, out_ready,
        output ack, out_valid, out_bits, out_last, out_src, busy
    );

    modport slave (
        output req, req_data, out_ready,
        input  ack, out_valid, out_bits, out_last, out_src, busy
    );
endinterface

// File: rtl/chunk_out_sched.sv
// Round-robin grant of one requester word, streamed LSB chunk first.
// Optional CHUNK_SCHED_TAG_EN prefixes each word with a winner-index chunk.
module chunk_out_sched #(
    parameter int NUM_REQ    = 4,
    parameter int CHUNK_BITS = 4,
    parameter int NUM_CHUNKS = 8
) (
    input logic              clk,
    input logic              reset,
    chunk_out_sched_if.master bus
);
    localparam int DATA_BITS = NUM_CHUNKS * CHUNK_BITS;
    localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [SRC_W-1:0] LAST_REQ = SRC_W'(NUM_REQ - 1);

`ifdef CHUNK_SCHED_TAG_EN
    if ($clog2(NUM_REQ) > CHUNK_BITS) begin : g_tag_width_chk
        $error("chunk_out_sched: requester index does not fit in one chunk");
    end
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        SEND = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   word_q, word_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SRC_W-1:0]       last_q, last_d;
    logic [SRC_W-1:0]       src_q, src_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;

    logic                   win_found;
    logic [SRC_W-1:0]       win_idx;
    int                     arb_idx;

    // Search starts one past the previous winner and wraps mod NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        arb_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_idx = int'(last_q) + k;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
            if (!win_found && bus.req[arb_idx]) begin
                win_found = 1'b1;
                win_idx   = SRC_W'(arb_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        src_d   = src_q;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    word_d         = bus.req_data[int'(win_idx)*DATA_BITS +: DATA_BITS];
                    last_d         = win_idx;
                    src_d          = win_idx;
                    ack_d[win_idx] = 1'b1;
                    cnt_d          = '0;
`ifdef CHUNK_SCHED_TAG_EN
                    state_d        = TAG;
`else
                    state_d        = SEND;
`endif
                end
            end
            TAG: begin
                if (bus.out_ready) state_d = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        word_d = word_q >> CHUNK_BITS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            last_q  <= LAST_REQ;
            src_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            src_q   <= src_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        bus.out_bits = '0;
        if (state_q == SEND) bus.out_bits = word_q[CHUNK_BITS-1:0];
`ifdef CHUNK_SCHED_TAG_EN
        if (state_q == TAG) bus.out_bits = CHUNK_BITS'(src_q);
`endif
    end

    assign bus.out_valid = (state_q != IDLE);
    assign bus.out_last  = (state_q == SEND) && (cnt_q == LAST_CNT);
    assign bus.out_src   = src_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.ack       = ack_q;
endmodule
